instr_stream_decoder: RTL and testbench
=======================================

// Module: instr_stream_decoder
// PURPOSE
//   Sequential successor to the combinational opcode decoder. Accepts the instruction stream one byte
//   per cycle over a valid/ready handshake, assembles variable-length instructions (1-4 bytes) and
//   emits one decoded instruction per out_valid/out_ready transfer. Sits between fetch and execute.
// PARAMETERS
//   BYTE_W     8   width of one stream byte; wide operand is 2*BYTE_W
//   REG_IDX_W  3   register index width; reg operands use operand[REG_IDX_W-1:0]
// PORTS
//   clk          in   1          clock, all logic on rising edge
//   rst          in   1          synchronous active-high reset
//   flush        in   1          sync; drops partial and held instruction
//   in_byte      in   BYTE_W     stream byte
//   in_valid     in   1          in_byte valid
//   in_ready     out  1          byte accepted when in_valid&in_ready
//   out_valid    out  1          decoded instruction held
//   out_ready    in   1          consumer takes instruction
//   out_ext      out  1          byte0[7]: extended format
//   out_class    out  3          byte0[6:4] op class (0 ADD/NOP,1 SUB,2 AND,3 OR,4 XOR,5 LOAD,6 STORE,7 STACK)
//   out_mode     out  4          byte0[3:0] operand mode
//   out_len      out  3          instruction length in bytes, 1..4
//   out_op1      out  2*BYTE_W   first operand, zero-extended when 8-bit
//   out_op2      out  BYTE_W     second operand, 0 when absent
//   out_illegal  out  1          illegal opcode flag (constant 0 without ILLEGAL_TRAP_EN)
// BEHAVIOUR
//   - Reset/flush: all outputs 0, in_ready=1, FSM->OPC, byte count 0. flush has priority over any
//     handshake in the same cycle; a byte presented with flush is dropped.
//   - Length from byte0: ext=1 -> 4 ([op][op1 16b LSB first][op2 8b]). ext=0, mode: 0 -> 1 (NOP when
//     byte0=0x00); 1 imm,imm / 2 reg,imm / 3 reg,reg -> 3; 4 imm8 -> 2; 5 imm16 -> 3; 6..15 illegal.
//   - FSM: OPC (wait byte0) -> OPND (collect len-1 bytes) -> OPC. Len-1 instruction completes in OPC.
//   - Completion: last byte's cycle writes the output register; out_valid rises next cycle (latency 1
//     clock from final byte accept). No combinational path in_byte -> out_*.
//   - Output held stable while out_valid & !out_ready.
//   - in_ready=1 except when the next accepted byte would complete an instruction while out_valid=1
//     and out_ready=0. Non-final bytes of the next instruction are collected while output is held.
//   - Simultaneous out_ready and completing byte: old instruction leaves, new one loads, out_valid
//     stays 1 (full throughput, one instruction per cycle for 1-byte ops).
//   - Reg modes: register operand truncated to REG_IDX_W bits, zero-extended into out_op1/out_op2.
//   - in_valid=0 mid-instruction: FSM waits indefinitely, partial bytes retained.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined: illegal mode -> 1-byte instruction, out_illegal=1, out_class/out_mode
//     from byte0, operands 0; consumer must trap.
//   ILLEGAL_TRAP_EN undefined: illegal mode decoded as 1-byte NOP (class 0, mode 0, len 1),
//     out_illegal tied 0.
// STRUCTURE
//   - Package decoder_pkg: CLS_* class codes, MODE_* operand-mode codes, instruction length
//     constants, FSM state encoding (OPC, OPND).
//   - Sub-module opcode_len_lut (combinational): byte0 -> {len, illegal}; shared with future fetch
//     predecode.
//   - Top: FSM, byte counter, operand shift regs, output register.
// TESTING
//   - Stream 0x00, out_ready=1 -> one cycle later out_valid=1, class 0, len 1; one instr per cycle.
//   - 0x01,0x05,0x07 -> class 0, mode 1, op1=0x0005, op2=0x07, len 3.
//   - 0x13,0x0A,0xFB (REG_IDX_W=3) -> class 1, mode 3, op1=0x0002, op2=0x03.
//   - 0x85,0x34,0x12,0x99 -> ext=1, op1=0x1234, op2=0x99, len 4.
//   - Hold out_ready=0, send 0x04,0x55,0x00 -> 0x04,0x55 accepted, in_ready=0 at 0x00; release ->
//     0x00 accepted same cycle as handoff.
//   - 0x0F: with ILLEGAL_TRAP_EN out_illegal=1, len 1; without, NOP. flush after 0x01,0x05 -> next
//     0x00 decodes as NOP.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared class/mode codes, length constants and FSM states for the instruction stream decoder
package decoder_pkg;

  typedef enum logic [2:0] {
    CLS_ADD   = 3'd0,
    CLS_SUB   = 3'd1,
    CLS_AND   = 3'd2,
    CLS_OR    = 3'd3,
    CLS_XOR   = 3'd4,
    CLS_LOAD  = 3'd5,
    CLS_STORE = 3'd6,
    CLS_STACK = 3'd7
  } cls_e;

  localparam logic [3:0] MODE_NONE    = 4'd0;
  localparam logic [3:0] MODE_IMM_IMM = 4'd1;
  localparam logic [3:0] MODE_REG_IMM = 4'd2;
  localparam logic [3:0] MODE_REG_REG = 4'd3;
  localparam logic [3:0] MODE_IMM8    = 4'd4;
  localparam logic [3:0] MODE_IMM16   = 4'd5;

  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_3 = 3'd3;
  localparam logic [2:0] LEN_4 = 3'd4;

  typedef enum logic {
    OPC  = 1'b0,
    OPND = 1'b1
  } state_e;

endpackage

// File: rtl/instr_stream_decoder_if.sv
// rtl/instr_stream_decoder_if.sv - byte stream in, decoded instruction out, with valid/ready on both sides
interface instr_stream_decoder_if #(
  parameter int BYTE_W = 8
);
  logic [BYTE_W-1:0]   in_byte;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic                out_ext;
  logic [2:0]          out_class;
  logic [3:0]          out_mode;
  logic [2:0]          out_len;
  logic [2*BYTE_W-1:0] out_op1;
  logic [BYTE_W-1:0]   out_op2;
  logic                out_illegal;

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_valid, out_ext, out_class, out_mode, out_len, out_op1, out_op2, out_illegal
  );

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_valid, out_ext, out_class, out_mode, out_len, out_op1, out_op2, out_illegal
  );
endinterface

// File: rtl/opcode_len_lut.sv
// rtl/opcode_len_lut.sv - combinational byte0 -> {instruction length, illegal mode} lookup
module opcode_len_lut
  import decoder_pkg::*;
(
  input  logic [7:0] i_byte0,
  output logic [2:0] o_len,
  output logic       o_illegal
);

  // Illegal modes report length 1 so the stream resynchronises on the next byte.
  always_comb begin
    o_len     = LEN_1;
    o_illegal = 1'b0;
    if (i_byte0[7]) begin
      o_len = LEN_4;
    end else begin
      case (i_byte0[3:0])
        MODE_NONE:                                        o_len = LEN_1;
        MODE_IMM_IMM, MODE_REG_IMM, MODE_REG_REG, MODE_IMM16: o_len = LEN_3;
        MODE_IMM8:                                        o_len = LEN_2;
        default:                                          o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_stream_decoder.sv
// rtl/instr_stream_decoder.sv - assembles 1-4 byte instructions from a byte stream; ILLEGAL_TRAP_EN flags illegal modes
module instr_stream_decoder
  import decoder_pkg::*;
#(
  parameter int BYTE_W    = 8,
  parameter int REG_IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  instr_stream_decoder_if.slave  bus
);

  localparam int OP1_W = 2 * BYTE_W;

  state_e              r_state;
  logic [2:0]          r_cnt;
  logic [2:0]          r_len;
  logic [BYTE_W-1:0]   r_b0, r_b1, r_b2;
  logic                r_out_valid, r_ext, r_ill;
  logic [2:0]          r_cls, r_olen;
  logic [3:0]          r_mode;
  logic [OP1_W-1:0]    r_op1;
  logic [BYTE_W-1:0]   r_op2;

  logic [2:0]          w_lut_len;
  logic                w_lut_ill;
  logic                w_final, w_in_ready, w_accept;
  logic [BYTE_W-1:0]   w_b0, w_b1, w_b2, w_b3;
  logic                w_ext, w_ill;
  logic [2:0]          w_cls, w_len;
  logic [3:0]          w_mode;
  logic [OP1_W-1:0]    w_op1;
  logic [BYTE_W-1:0]   w_op2;

  opcode_len_lut u_lut (
    .i_byte0   (bus.in_byte[7:0]),
    .o_len     (w_lut_len),
    .o_illegal (w_lut_ill)
  );

  // A completing byte is refused only when the held instruction cannot leave this cycle.
  assign w_final    = (r_state == OPC) ? (w_lut_len == LEN_1) : (r_cnt + 3'd1 == r_len);
  assign w_in_ready = !(w_final && r_out_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !flush;

  assign w_b0 = (r_state == OPC) ? bus.in_byte : r_b0;
  assign w_b1 = (r_cnt == 3'd1) ? bus.in_byte : r_b1;
  assign w_b2 = (r_cnt == 3'd2) ? bus.in_byte : r_b2;
  assign w_b3 = bus.in_byte;

  always_comb begin
    w_ext  = w_b0[7];
    w_cls  = w_b0[6:4];
    w_mode = w_b0[3:0];
    w_len  = (r_state == OPC) ? w_lut_len : r_len;
    w_op1  = '0;
    w_op2  = '0;
    w_ill  = 1'b0;
    if (w_ext) begin
      w_op1 = {w_b2, w_b1};
      w_op2 = w_b3;
    end else if ((r_state == OPC) && w_lut_ill) begin
`ifdef ILLEGAL_TRAP_EN
      w_ill = 1'b1;
`else
      w_cls  = CLS_ADD;
      w_mode = MODE_NONE;
`endif
    end else begin
      case (w_b0[3:0])
        MODE_IMM_IMM: begin w_op1 = OP1_W'(w_b1); w_op2 = w_b2; end
        MODE_REG_IMM: begin w_op1 = OP1_W'(w_b1[REG_IDX_W-1:0]); w_op2 = w_b2; end
        MODE_REG_REG: begin
          w_op1 = OP1_W'(w_b1[REG_IDX_W-1:0]);
          w_op2 = BYTE_W'(w_b2[REG_IDX_W-1:0]);
        end
        MODE_IMM8:    w_op1 = OP1_W'(w_b1);
        MODE_IMM16:   w_op1 = {w_b2, w_b1};
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= OPC;
      r_cnt       <= '0;
      r_len       <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_out_valid <= 1'b0;
      r_ext       <= 1'b0;
      r_ill       <= 1'b0;
      r_cls       <= '0;
      r_olen      <= '0;
      r_mode      <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
    end else begin
      if (w_accept) begin
        if (w_final) begin
          r_state <= OPC;
          r_cnt   <= '0;
        end else if (r_state == OPC) begin
          r_state <= OPND;
          r_cnt   <= 3'd1;
          r_len   <= w_lut_len;
          r_b0    <= bus.in_byte;
        end else begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd1) r_b1 <= bus.in_byte;
          if (r_cnt == 3'd2) r_b2 <= bus.in_byte;
        end
      end
      // Loading wins over draining so a back-to-back handoff keeps out_valid high.
      if (w_accept && w_final) begin
        r_out_valid <= 1'b1;
        r_ext       <= w_ext;
        r_ill       <= w_ill;
        r_cls       <= w_cls;
        r_olen      <= w_len;
        r_mode      <= w_mode;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_ext     = r_ext;
  assign bus.out_class   = r_cls;
  assign bus.out_mode    = r_mode;
  assign bus.out_len     = r_olen;
  assign bus.out_op1     = r_op1;
  assign bus.out_op2     = r_op2;
  assign bus.out_illegal = r_ill;

endmodule

// File: tb/tb_instr_stream_decoder.sv
// tb/tb_instr_stream_decoder.sv - self-checking bench for instr_stream_decoder
module tb_instr_stream_decoder;

  typedef struct packed {
    logic        ext;
    logic [2:0]  cls;
    logic [3:0]  mode;
    logic [2:0]  len;
    logic [15:0] op1;
    logic [7:0]  op2;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [7:0] b [4];
    int         n;
    exp_t       e;
  } vec_t;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  instr_stream_decoder_if #(.BYTE_W(8)) bus ();

  instr_stream_decoder #(.BYTE_W(8), .REG_IDX_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  bit   rnd_ready = 1'b0;
  vec_t vecs[12];

  function automatic exp_t cur();
    cur = {bus.out_ext, bus.out_class, bus.out_mode, bus.out_len, bus.out_op1, bus.out_op2, bus.out_illegal};
  endfunction

  function automatic int model_len(logic [7:0] b0);
    if (b0[7]) return 4;
    case (b0[3:0])
      4'd0:                   return 1;
      4'd1, 4'd2, 4'd3, 4'd5: return 3;
      4'd4:                   return 2;
      default:                return 1;
    endcase
  endfunction

  function automatic exp_t model(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    exp_t e;
    int   m;
    m      = int'(b0[3:0]);
    e      = '0;
    e.ext  = b0[7];
    e.cls  = b0[6:4];
    e.mode = b0[3:0];
    e.len  = 3'(model_len(b0));
    if (b0[7]) begin
      e.op1 = 16'(int'(b2) * 256 + int'(b1));
      e.op2 = b3;
    end else if (m == 1) begin
      e.op1 = 16'(b1); e.op2 = b2;
    end else if (m == 2) begin
      e.op1 = 16'(int'(b1) % 8); e.op2 = b2;
    end else if (m == 3) begin
      e.op1 = 16'(int'(b1) % 8); e.op2 = 8'(int'(b2) % 8);
    end else if (m == 4) begin
      e.op1 = 16'(b1);
    end else if (m == 5) begin
      e.op1 = 16'(int'(b2) * 256 + int'(b1));
    end else if (m > 5) begin
      e.ill  = TRAP;
      e.cls  = TRAP ? b0[6:4] : 3'd0;
      e.mode = TRAP ? b0[3:0] : 4'd0;
    end
    return e;
  endfunction

  function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                              logic ext, logic [2:0] cls, logic [3:0] mode, logic [2:0] len,
                              logic [15:0] op1, logic [7:0] op2, logic ill);
    vec_t v;
    v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.e = {ext, cls, mode, len, op1, op2, ill};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t a, e;
    if (mon_en && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      a = cur();
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h, required no transfer", a);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", 64'(a), 64'(e));
      end
    end
  end

  task automatic step();
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    forever begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_ready) break;
      @(posedge clk);
      #1;
      waits++;
      if (waits > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready 0 for byte %h, required 1", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    rnd_ready     = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d instructions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb [4];
    int         n;

    vecs[0]  = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3'd0, 4'd0, 3'd1, 16'h0000, 8'h00, 0);
    vecs[1]  = mk(3, 8'h01, 8'h05, 8'h07, 8'h00, 0, 3'd0, 4'd1, 3'd3, 16'h0005, 8'h07, 0);
    vecs[2]  = mk(3, 8'h13, 8'h0A, 8'hFB, 8'h00, 0, 3'd1, 4'd3, 3'd3, 16'h0002, 8'h03, 0);
    vecs[3]  = mk(4, 8'h85, 8'h34, 8'h12, 8'h99, 1, 3'd0, 4'd5, 3'd4, 16'h1234, 8'h99, 0);
    vecs[4]  = mk(2, 8'h24, 8'hAB, 8'h00, 8'h00, 0, 3'd2, 4'd4, 3'd2, 16'h00AB, 8'h00, 0);
    vecs[5]  = mk(3, 8'h35, 8'hCD, 8'hAB, 8'h00, 0, 3'd3, 4'd5, 3'd3, 16'hABCD, 8'h00, 0);
    vecs[6]  = mk(3, 8'h42, 8'hFF, 8'h3C, 8'h00, 0, 3'd4, 4'd2, 3'd3, 16'h0007, 8'h3C, 0);
    vecs[7]  = mk(1, 8'h70, 8'h00, 8'h00, 8'h00, 0, 3'd7, 4'd0, 3'd1, 16'h0000, 8'h00, 0);
    vecs[8]  = mk(1, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 3'd0, TRAP ? 4'hF : 4'h0, 3'd1, 16'h0000, 8'h00, TRAP);
    vecs[9]  = mk(4, 8'hE6, 8'h01, 8'h02, 8'h03, 1, 3'd6, 4'd6, 3'd4, 16'h0201, 8'h03, 0);
    vecs[10] = mk(1, 8'h5A, 8'h00, 8'h00, 8'h00, 0, TRAP ? 3'd5 : 3'd0, TRAP ? 4'hA : 4'h0, 3'd1, 16'h0000, 8'h00, TRAP);
    vecs[11] = mk(4, 8'hC0, 8'hAA, 8'hBB, 8'hCC, 1, 3'd4, 4'd0, 3'd4, 16'hBBAA, 8'hCC, 0);

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outputs", 64'(cur()), 64'd0);
    @(posedge clk);
    #1;

    // NOP latency and one-per-cycle throughput
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(model(8'h00, 8'h00, 8'h00, 8'h00));
    bus.in_byte = 8'h00; bus.in_valid = 1'b1;
    @(negedge clk);
    check("lat_before_accept", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_one_cycle", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(8'h00, 8'h00, 8'h00, 8'h00));
      @(negedge clk);
      check("tput_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      check("tput_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(vecs[i].e);
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
      wait_drain();
    end

    // completing byte stalls behind a held instruction, then hands off in one cycle
    bus.out_ready = 1'b0;
    exp_q.push_back(model(8'h04, 8'h55, 8'h00, 8'h00));
    send_byte(8'h04);
    send_byte(8'h55);
    exp_q.push_back(model(8'h00, 8'h00, 8'h00, 8'h00));
    bus.in_byte = 8'h00; bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      check("bp_held_op1", 64'(bus.out_op1), 64'h55);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_handoff_valid", 64'(bus.out_valid), 64'd1);
    check("bp_handoff_len", 64'(bus.out_len), 64'd1);
    wait_drain();

    // non-final bytes are collected while the output is held
    bus.out_ready = 1'b0;
    exp_q.push_back(model(8'h24, 8'h11, 8'h00, 8'h00));
    send_byte(8'h24);
    send_byte(8'h11);
    exp_q.push_back(model(8'h01, 8'h05, 8'h07, 8'h00));
    send_byte(8'h01);
    send_byte(8'h05);
    bus.in_byte = 8'h07; bus.in_valid = 1'b1;
    @(negedge clk);
    check("hold_final_blocked", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_final_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();

    // flush drops a partial instruction
    send_byte(8'h01);
    send_byte(8'h05);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.push_back(model(8'h00, 8'h00, 8'h00, 8'h00));
    send_byte(8'h00);
    wait_drain();

    // flush drops a held instruction and a byte presented alongside it
    bus.out_ready = 1'b0;
    send_byte(8'h04);
    send_byte(8'h55);
    @(negedge clk);
    check("flush_pre_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; bus.in_byte = 8'h00; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_outputs", 64'(cur()), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    exp_q.push_back(model(8'h70, 8'h00, 8'h00, 8'h00));
    send_byte(8'h70);
    wait_drain();

    // random instruction stream with random gaps and backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      for (int j = 0; j < 4; j++) rb[j] = 8'($urandom);
      n = model_len(rb[0]);
      exp_q.push_back(model(rb[0], rb[1], rb[2], rb[3]));
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) step();
        send_byte(rb[j]);
      end
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
